// File: rtl/pattern_pkg.sv
// Types and constants shared by the binary-frame capture and read-out paths.
// The state enum is also used as the capture-side state type.
package pattern_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        COMPLETE = 2'd2
    } rd_state_e;

    localparam logic [7:0] PIX_WHITE = 8'd255;
    localparam logic [7:0] PIX_BLACK = 8'd0;

    // One buffered pixel: captured bit plus its frame/line markers.
    typedef struct packed {
        logic pix;
        logic sof;
        logic eol;
        logic eof;
    } pix_tag_t;

    function automatic int total_pixels(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/bram_reader_if.sv
// Pixel stream carrying 8-bit pixels with frame/line markers on a valid/ready handshake.
interface bram_reader_if;
    logic       y_valid;
    logic       y_ready;
    logic [7:0] y_data;
    logic       y_sof;
    logic       y_eol;
    logic       y_eof;

    modport master (output y_valid, y_data, y_sof, y_eol, y_eof, input y_ready);
    modport slave  (input y_valid, y_data, y_sof, y_eol, y_eof, output y_ready);
endinterface

// File: rtl/bram_reader_skid.sv
// Two-entry register buffer; entry 0 is the head and drives the stream directly.
module bram_reader_skid
    import pattern_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  pix_tag_t   push_ent,
    input  logic       pop,
    output pix_tag_t   head,
    output logic [1:0] count
);

    pix_tag_t   e0_q, e0_d, e1_q, e1_d;
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = push_ent;
                else               e1_d = push_ent;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push/pop: the new entry lands behind whatever remains.
                if (cnt_q == 2'd2) begin
                    e0_d = e1_q;
                    e1_d = push_ent;
                end else begin
                    e0_d = push_ent;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = e0_q;
    assign count = cnt_q;

endmodule

// File: rtl/bram_reader.sv
// Streams a captured 1-bit frame out of BRAM as 8-bit pixels on a valid/ready
// stream, tagging start of frame, end of line and end of frame.
module bram_reader
    import pattern_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_trigger,
    input  logic              frame_valid,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_data,
    bram_reader_if.master     y,
    output logic              reading,
    output logic              read_complete
);

    localparam int                XW        = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [XW-1:0]     X_LAST    = XW'(IMG_WIDTH - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(total_pixels(IMG_WIDTH, IMG_HEIGHT) - 1);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XW-1:0]     x_q, x_d;
    logic              addr_rem_q, addr_rem_d;
    logic              inflight_q, inflight_d;
    logic [2:0]        tag_q, tag_d;

    pix_tag_t   head;
    logic [1:0] buf_cnt;
    logic       out_valid;
    logic       pop;
    logic       issue;
    logic [2:0] occ;

    assign out_valid = (buf_cnt != 2'd0);
    assign pop       = out_valid && y.y_ready;
    // Slots already claimed once this cycle's pop is accounted for.
    assign occ       = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = (state_q == STREAM) && addr_rem_q && (occ < 3'd2);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        x_d        = x_q;
        addr_rem_d = addr_rem_q;
        inflight_d = issue;
        tag_d      = {(addr_q == '0), (x_q == X_LAST), (addr_q == LAST_ADDR)};
        case (state_q)
            IDLE: begin
                if (start_trigger && frame_valid) begin
                    state_d    = STREAM;
                    addr_d     = '0;
                    x_d        = '0;
                    addr_rem_d = 1'b1;
                end
            end
            STREAM: begin
                if (issue) begin
                    if (addr_q == LAST_ADDR) addr_rem_d = 1'b0;
                    else                     addr_d     = addr_q + ADDR_W'(1);
                    x_d = (x_q == X_LAST) ? '0 : x_q + XW'(1);
                end
                if (pop && head.eof) state_d = COMPLETE;
            end
            COMPLETE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            x_q        <= '0;
            addr_rem_q <= 1'b0;
            inflight_q <= 1'b0;
            tag_q      <= 3'b000;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            x_q        <= x_d;
            addr_rem_q <= addr_rem_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end

    bram_reader_skid u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight_q),
        .push_ent ({rd_data, tag_q}),
        .pop      (pop),
        .head     (head),
        .count    (buf_cnt)
    );

    assign rd_en         = issue;
    assign rd_addr       = addr_q;
    assign y.y_valid     = out_valid;
    assign y.y_data      = head.pix ? PIX_WHITE : PIX_BLACK;
    assign y.y_sof       = out_valid && head.sof;
    assign y.y_eol       = out_valid && head.eol;
    assign y.y_eof       = out_valid && head.eof;
    assign reading       = (state_q == STREAM);
    assign read_complete = (state_q == COMPLETE);

endmodule

// File: tb/tb_bram_reader.sv
// Directed bench for bram_reader on a 4x3 frame with a 1-cycle-latency BRAM model.
module tb_bram_reader;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int TOT = 12;
    localparam int AW  = $clog2(TOT);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_trigger = 1'b0;
    logic          frame_valid = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_data = 1'b0;
    logic          reading;
    logic          read_complete;

    bram_reader_if y_if ();

    bram_reader #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_trigger (start_trigger),
        .frame_valid   (frame_valid),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .y             (y_if),
        .reading       (reading),
        .read_complete (read_complete)
    );

    always #5 clk = ~clk;

    // BRAM contents for addresses 0..11: 1,0,1,1,0,0,0,1,1,1,0,1
    logic [TOT-1:0] pat = 12'b1011_1000_1101;
    always @(posedge clk) if (rd_en) rd_data <= pat[rd_addr];

    // Expected output, written out by hand.
    int exp_pix [12] = '{255, 0, 255, 255, 0, 0, 0, 255, 255, 255, 0, 255};
    bit exp_eol [12] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Stream monitor, sampled on the falling edge.
    logic [10:0] cur;
    assign cur = {y_if.y_data, y_if.y_sof, y_if.y_eol, y_if.y_eof};

    int          cyc = 0;
    int          rd_cnt, hs_cnt, rc_cnt, rc_cyc, viol, stab_viol;
    int          trig_cyc, first_rd_cyc, first_v_cyc;
    bit          valid_seen, reading_seen, stall_prev, pop_m;
    logic [10:0] held;
    logic [10:0] px_q[$];
    int          hs_cyc[$];

    task automatic clr_mon();
        rd_cnt = 0; hs_cnt = 0; rc_cnt = 0; rc_cyc = -1; viol = 0; stab_viol = 0;
        trig_cyc = -1; first_rd_cyc = -1; first_v_cyc = -1;
        valid_seen = 0; reading_seen = 0; stall_prev = 0;
        px_q.delete(); hs_cyc.delete();
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            stall_prev = 0;
        end else begin
            pop_m = y_if.y_valid && y_if.y_ready;
            if (rd_en && ((rd_cnt - hs_cnt) - (pop_m ? 1 : 0)) >= 2) viol++;
            if (stall_prev && (!y_if.y_valid || cur != held)) stab_viol++;
            if (start_trigger && trig_cyc < 0) trig_cyc = cyc;
            if (rd_en) begin
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                rd_cnt++;
            end
            if (y_if.y_valid) begin
                valid_seen = 1;
                if (first_v_cyc < 0) first_v_cyc = cyc;
            end
            if (reading) reading_seen = 1;
            if (pop_m) begin
                px_q.push_back(cur);
                hs_cyc.push_back(cyc);
                hs_cnt++;
            end
            if (read_complete) begin
                rc_cnt++;
                rc_cyc = cyc;
            end
            stall_prev = y_if.y_valid && !y_if.y_ready;
            held       = cur;
        end
    end

    function automatic int all_outs();
        return int'({rd_en, rd_addr, y_if.y_valid, y_if.y_data, y_if.y_sof,
                     y_if.y_eol, y_if.y_eof, reading, read_complete});
    endfunction

    // mode 0: ready=1; 1: random ready; 2: 10-cycle stall after first valid;
    // 3: extra triggers mid-stream, in COMPLETE and in the next IDLE; 4: stop after pixel 5
    task automatic run_frame(input int mode, input int nframes);
        int n = 0;
        int stall_left = 10;
        bit to = 0;
        frame_valid = 1'b1;
        while (1) begin
            @(posedge clk); #1;
            start_trigger = (n == 0) || (mode == 3 && (n == 6 || n == 15 || n == 16));
            case (mode)
                1: y_if.y_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (first_v_cyc < 0) y_if.y_ready = 1'b0;
                    else if (stall_left > 0) begin
                        y_if.y_ready = 1'b0;
                        stall_left--;
                        if (stall_left == 0) begin
                            chk("stall_reads_le2", int'(rd_cnt <= 2), 1);
                            chk("stall_data", int'(y_if.y_data), 255);
                            chk("stall_valid", int'(y_if.y_valid), 1);
                        end
                    end else y_if.y_ready = 1'b1;
                end
                default: y_if.y_ready = 1'b1;
            endcase
            n++;
            if (mode == 4 && hs_cnt >= 6) break;
            if (mode != 4 && rc_cnt >= nframes) break;
            if (n > 300) begin
                to = 1;
                break;
            end
        end
        start_trigger = 1'b0;
        chk("no_timeout", int'(to), 0);
    endtask

    task automatic check_pixels(input int base);
        for (int i = 0; i < 12; i++) begin
            if (base + i < px_q.size())
                chk($sformatf("px%0d", base + i), int'(px_q[base + i]),
                    int'({exp_pix[i][7:0], i == 0, exp_eol[i], i == 11}));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        y_if.y_ready = 1'b1;
        clr_mon();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", all_outs(), 0);
        rst_n = 1'b1;

        // Basic frame with ready held high.
        clr_mon();
        run_frame(0, 1);
        repeat (4) @(posedge clk);
        chk("first_rd_lat", first_rd_cyc - trig_cyc, 1);
        chk("first_valid_lat", first_v_cyc - trig_cyc, 3);
        chk("npix", px_q.size(), 12);
        check_pixels(0);
        chk("rc_count", rc_cnt, 1);
        chk("rc_after_last", rc_cyc - hs_cyc[11], 1);
        chk("no_bubbles", hs_cyc[11] - hs_cyc[0], 11);
        chk("occ_viol", viol, 0);

        // Trigger without a valid frame.
        @(posedge clk); #1;
        clr_mon();
        frame_valid   = 1'b0;
        start_trigger = 1'b1;
        @(posedge clk); #1;
        start_trigger = 1'b0;
        repeat (10) @(posedge clk);
        chk("fv0_reads", rd_cnt, 0);
        chk("fv0_reading", int'(reading_seen), 0);
        chk("fv0_valid", int'(valid_seen), 0);

        // Random backpressure.
        clr_mon();
        run_frame(1, 1);
        repeat (4) @(posedge clk);
        chk("rand_npix", px_q.size(), 12);
        check_pixels(0);
        chk("rand_occ_viol", viol, 0);
        chk("rand_stable", stab_viol, 0);
        chk("rand_rc", rc_cnt, 1);

        // Long stall right after the first valid pixel.
        clr_mon();
        run_frame(2, 1);
        repeat (4) @(posedge clk);
        chk("stall_npix", px_q.size(), 12);
        check_pixels(0);
        chk("stall_burst", hs_cyc[11] - hs_cyc[0], 11);
        chk("stall_stable", stab_viol, 0);
        chk("stall_occ_viol", viol, 0);

        // Ignored triggers, then a second frame from the first IDLE cycle.
        clr_mon();
        run_frame(3, 2);
        repeat (4) @(posedge clk);
        chk("two_npix", px_q.size(), 24);
        check_pixels(0);
        check_pixels(12);
        chk("two_rc", rc_cnt, 2);
        if (hs_cyc.size() >= 13) chk("f2_gap", hs_cyc[12] - hs_cyc[11], 5);
        else chk("f2_present", hs_cyc.size(), 13);

        // Reset in the middle of a frame, then restart.
        clr_mon();
        run_frame(4, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", all_outs(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clr_mon();
        run_frame(0, 1);
        repeat (4) @(posedge clk);
        chk("rst_first_valid_lat", first_v_cyc - trig_cyc, 3);
        chk("rst_npix", px_q.size(), 12);
        check_pixels(0);
        chk("rst_rc", rc_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bram_reader.md
Name: bram_reader

Overview:
Streaming read-out engine for a captured 1-bit binary frame. On trigger, it walks the frame BRAM from address 0 to TOTAL_PIXELS-1 through a 1-cycle-latency synchronous read port. It re-expands each bit to an 8-bit pixel (1 -> 255, 0 -> 0) and emits it on a valid/ready stream with frame and line markers. It is the consumer-side counterpart of the frame capture path and feeds pattern-recognition stages.

Parameters:
IMG_WIDTH, 640, pixels per line
IMG_HEIGHT, 480, lines per frame
ADDR_W, $clog2(IMG_WIDTH*IMG_HEIGHT), BRAM address width (derived, do not override)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start_trigger  input  1  pulse to start streaming one frame
frame_valid  input  1  high while BRAM holds a complete captured frame
rd_en  output  1  BRAM read enable
rd_addr  output  ADDR_W  BRAM read address
rd_data  input  1  BRAM read data, valid the cycle after rd_en
y_valid  output  1  output pixel valid
y_ready  input  1  downstream ready
y_data  output  8  pixel, 8'd255 or 8'd0
y_sof  output  1  qualifies first pixel of frame (address 0)
y_eol  output  1  qualifies last pixel of each line
y_eof  output  1  qualifies last pixel of frame
reading  output  1  high from trigger acceptance until the last pixel handshake
read_complete  output  1  one-cycle pulse after the last pixel handshake

Behaviour:
- Reset (async): state=IDLE, rd_addr=0, rd_en=0, y_valid=0, y_sof/y_eol/y_eof=0, y_data=0, reading=0, read_complete=0, skid buffer emptied, in-flight flag cleared, x/y counters=0.
- Reset mid-frame: the stream aborts immediately; no partial-frame markers; the next trigger restarts at address 0.
- States: IDLE, STREAM, COMPLETE.
- IDLE: if start_trigger && frame_valid, go to STREAM and set reading=1, rd_addr=0. A trigger with frame_valid=0 is ignored.
- start_trigger is ignored in STREAM and COMPLETE (no restart, no queuing).
- STREAM, read issue: rd_en=1 when addr_remaining && (buf_count + inflight - pop) < 2, where pop = y_valid && y_ready.
  - On issue, rd_addr increments the following cycle.
  - No address is issued past TOTAL_PIXELS-1; rd_addr does not wrap within a frame.
- Returning data: rd_data is captured into a 2-entry skid buffer the cycle after issue, together with sof/eol/eof tags computed from the issued address.
  - eol: x counter == IMG_WIDTH-1.
  - eof: address == TOTAL_PIXELS-1.
- Output: y_valid/y_data/tags come from the buffer head, and are registered.
  - y_data, y_sof, y_eol and y_eof hold stable while y_valid && !y_ready.
  - Buffer push and pop in the same cycle are legal; count is unchanged.
- Latency: trigger sampled at edge T; first rd_en during cycle T+1; y_valid first high during cycle T+3.
- Throughput: with y_ready held 1, one pixel per cycle sustained; no bubbles after the first pixel.
- Backpressure: BRAM is never read into a full buffer; no pixel is lost or duplicated.
- A pixel with y_eof transferred moves the block to COMPLETE.
  - COMPLETE lasts one cycle: read_complete=1, reading=0, then back to IDLE.
- A new trigger is accepted from the first IDLE cycle after COMPLETE.
- frame_valid is sampled only at trigger acceptance. Deassertion mid-stream does not abort.

Decomposition:
- Shared package pattern_pkg:
  - bram_reader state enum (IDLE/STREAM/COMPLETE, 2-bit), shared with the capture-side state type.
  - PIX_WHITE=8'd255 and PIX_BLACK=8'd0, also used by the writer's binarisation compare.
  - A function returning TOTAL_PIXELS from width and height.
- One sub-module: bram_reader_skid. It is a 2-entry register buffer carrying {bit, sof, eol, eof}, with push/pop/count and a registered head.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=3, TOTAL=12; BRAM model has 1-cycle latency, preloaded with pattern 1,0,1,1,0,0,0,1,1,1,0,1):
- Trigger with frame_valid=1 and y_ready=1 -> first y_valid 3 cycles after the trigger edge. Twelve consecutive pixels: 255,0,255,255,0,0,0,255,255,255,0,255. y_sof on pixel 0; y_eol on pixels 3, 7, 11; y_eof on pixel 11. read_complete pulses exactly once, one cycle after pixel 11.
- Trigger with frame_valid=0 -> reading stays 0, rd_en never asserts, no y_valid.
- Random y_ready (~50% duty) -> the same 12 values in order, no drops or duplicates. Outputs stable while stalled. rd_en never issued when buffer+in-flight equals 2.
- y_ready=0 for 10 cycles after the first valid -> at most 2 reads issued, y_data holds 255. After release, the remaining pixels stream at 1/cycle.
- start_trigger pulsed mid-stream, and again in the COMPLETE cycle -> ignored, single frame of 12 pixels. A trigger in the following IDLE cycle starts a second identical frame.
- rst_n asserted after pixel 5 -> all outputs 0 immediately. A re-trigger streams from address 0 with y_sof on the first pixel.
